// File: rtl/store_rmw_unit.sv
// Store read-modify-write unit: turns SB/SH/SW requests into full-word memory
// accesses, reading and merging the target word for sub-word stores.
module store_rmw_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        fun3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err,
    output logic              busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;

    localparam logic [2:0] F_SB = 3'b000;
    localparam logic [2:0] F_SH = 3'b001;
    localparam logic [2:0] F_SW = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MERGE,
        WRITE,
        ERR
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              accept;
    logic              illegal;
    logic              misaligned;
    logic [1:0]        off_q;
    logic              half_q;
    logic [HALF_W-1:0] wdata_q;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] merged;

    logic              mem_rd_d;
    logic              mem_wr_d;
    logic              done_d;
    logic              err_d;
    logic              busy_d;
    logic              ready_d;

    assign accept     = req_valid && req_ready;
    assign illegal    = (fun3 != F_SB) && (fun3 != F_SH) && (fun3 != F_SW);
    assign misaligned = ((fun3 == F_SH) && addr[0]) ||
                        ((fun3 == F_SW) && (addr[1:0] != 2'b00));

    // The write word is always driven straight from the merge register.
    assign mem_wdata = word_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and decode of the registered outputs from the next state.
    always_comb begin
        state_d  = state_q;
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        busy_d   = 1'b0;
        ready_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (illegal || misaligned) begin
                        state_d = ERR;
                    end else if (fun3 == F_SW) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:    state_d = MERGE;
            MERGE:   state_d = WRITE;
            WRITE:   state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        mem_rd_d = (state_d == READ);
        mem_wr_d = (state_d == WRITE);
        done_d   = (state_d == WRITE);
        err_d    = (state_d == ERR);
        busy_d   = (state_d != IDLE);
        ready_d  = (state_d == IDLE);
    end

    // Replace the addressed byte or halfword lane of the read word.
    always_comb begin
        merged = mem_rdata;
        if (half_q) begin
            if (off_q[1]) begin
                merged[31:16] = wdata_q;
            end else begin
                merged[15:0] = wdata_q;
            end
        end else begin
            case (off_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end
    end

    // Request latch and merge register; SW data goes straight to the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q    <= 2'b00;
            half_q   <= 1'b0;
            wdata_q  <= '0;
            word_q   <= '0;
            mem_addr <= '0;
        end else if (accept) begin
            off_q    <= addr[1:0];
            half_q   <= (fun3 == F_SH);
            wdata_q  <= wdata[HALF_W-1:0];
            word_q   <= wdata;
            mem_addr <= {addr[ADDR_W-1:2], 2'b00};
        end else if (state_q == MERGE) begin
            word_q   <= merged;
        end
    end

    // Registered status and strobe outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            mem_rd    <= mem_rd_d;
            mem_wr    <= mem_wr_d;
            done      <= done_d;
            err       <= err_d;
            busy      <= busy_d;
            req_ready <= ready_d;
        end
    end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: vector table with a write scoreboard, plus
// hand-written reset and back-to-back sequences.
module tb_store_rmw_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  fun3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [31:0] rd_word = 32'h0;

    typedef struct {
        logic [2:0]  fun3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          exp_err;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t  sb_q[$];
    vec_t vecs[14];

    store_rmw_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .fun3      (fun3),
        .addr      (addr),
        .wdata     (wdata),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .done      (done),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data appears the cycle after mem_rd, garbage otherwise.
    always @(posedge clk) mem_rdata <= mem_rd ? rd_word : 32'h0BAD0BAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor / scoreboard and per-cycle protocol checks.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (mem_wr || mem_rd) check("rd_wr_exclusive", {31'b0, mem_rd && mem_wr}, 32'h0);
            if (mem_wr || done) check("done_with_wr", {31'b0, done}, {31'b0, mem_wr});
            if (err) check("err_no_mem", {30'b0, mem_rd, mem_wr}, 32'h0);
            if (mem_wr) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_wr", 32'h1, 32'h0);
                end else begin
                    wr_t e;
                    e = sb_q.pop_front();
                    check("wr_addr", mem_addr, e.addr);
                    check("wr_data", mem_wdata, e.data);
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check({name, "_ready_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int rd_cyc;
        bit saw_err;
        int exp_rd;
        wait_ready($sformatf("v%0d", idx));
        req_valid = 1'b1;
        fun3      = v.fun3;
        addr      = v.addr;
        wdata     = v.wdata;
        rd_word   = v.rdata;
        if (!v.exp_err) sb_q.push_back('{v.exp_addr, v.exp_wdata});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        fun3      = 3'b010;
        addr      = 32'hFFFF_FFFF;
        wdata     = 32'h5A5A_5A5A;
        lat = 0;
        rd_cyc = 0;
        saw_err = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (mem_rd && rd_cyc == 0) begin
                rd_cyc = c;
                check($sformatf("v%0d_rd_addr", idx), mem_addr, v.exp_addr);
            end
            if (err) saw_err = 1'b1;
            if ((done || err) && lat == 0) lat = c;
        end
        exp_rd = (!v.exp_err && v.exp_lat == 3) ? 1 : 0;
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d_err", idx), {31'b0, saw_err}, {31'b0, v.exp_err});
        check($sformatf("v%0d_rd_cycle", idx), 32'(rd_cyc), 32'(exp_rd));
    endtask

    initial begin
        int acc[3];
        int d0;

        vecs[0]  = '{3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,          1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 1};
        vecs[1]  = '{3'b000, 32'h0000_0102, 32'h0000_00AA, 32'h1122_3344, 1'b0, 32'h0000_0100, 32'h11AA_3344, 3};
        vecs[2]  = '{3'b001, 32'h0000_0206, 32'h0000_BEEF, 32'hCAFE_F00D, 1'b0, 32'h0000_0204, 32'hBEEF_F00D, 3};
        vecs[3]  = '{3'b001, 32'h0000_0101, 32'h0000_1234, 32'h0,          1'b1, 32'h0,          32'h0,          1};
        vecs[4]  = '{3'b011, 32'h0000_0100, 32'h0000_1234, 32'h0,          1'b1, 32'h0,          32'h0,          1};
        vecs[5]  = '{3'b000, 32'h0000_0103, 32'hFFFF_FF55, 32'h0000_0000, 1'b0, 32'h0000_0100, 32'h5500_0000, 3};
        vecs[6]  = '{3'b000, 32'h0000_0000, 32'h0000_0012, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'hFFFF_FF12, 3};
        vecs[7]  = '{3'b001, 32'h0000_0004, 32'hFFFF_1234, 32'hAAAA_AAAA, 1'b0, 32'h0000_0004, 32'hAAAA_1234, 3};
        vecs[8]  = '{3'b010, 32'h0000_0102, 32'h1111_1111, 32'h0,          1'b1, 32'h0,          32'h0,          1};
        vecs[9]  = '{3'b010, 32'hFFFF_FFFC, 32'h0123_4567, 32'h0,          1'b0, 32'hFFFF_FFFC, 32'h0123_4567, 1};
        vecs[10] = '{3'b111, 32'h0000_0000, 32'h0,          32'h0,          1'b1, 32'h0,          32'h0,          1};
        vecs[11] = '{3'b100, 32'h0000_0000, 32'h0,          32'h0,          1'b1, 32'h0,          32'h0,          1};
        vecs[12] = '{3'b000, 32'hFFFF_FFFD, 32'h0000_009A, 32'h7654_3210, 1'b0, 32'hFFFF_FFFC, 32'h7654_9A10, 3};
        vecs[13] = '{3'b010, 32'h0000_0001, 32'h0,          32'h0,          1'b1, 32'h0,          32'h0,          1};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        fun3      = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;

        // Reset state.
        #3;
        check("rst_mem_rd", {31'b0, mem_rd}, 32'h0);
        check("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
        check("rst_done_err_busy", {29'b0, done, err, busy}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'b0, req_ready}, 32'h1);
        check("post_rst_busy", {31'b0, busy}, 32'h0);

        // Table-driven vectors.
        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Reset asserted while an SB is in MERGE: store must be abandoned.
        wait_ready("midrst");
        req_valid = 1'b1;
        fun3      = 3'b000;
        addr      = 32'h0000_0102;
        wdata     = 32'h0000_00AA;
        rd_word   = 32'h1122_3344;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("midrst_read", {31'b0, mem_rd}, 32'h1);
        @(negedge clk);
        check("midrst_in_merge", {31'b0, busy && !mem_rd && !mem_wr}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_async_busy", {31'b0, busy}, 32'h0);
        check("midrst_async_strobes", {28'b0, mem_rd, mem_wr, done, err}, 32'h0);
        check("midrst_async_addr", mem_addr, 32'h0);
        check("midrst_async_wdata", mem_wdata, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0], 100);

        // Three SW requests with req_valid held high.
        d0 = done_cnt;
        sb_q.push_back('{32'h0000_0300, 32'hA000_0001});
        sb_q.push_back('{32'h0000_0304, 32'hA000_0002});
        sb_q.push_back('{32'h0000_0308, 32'hA000_0003});
        wait_ready("b2b_start");
        req_valid = 1'b1;
        fun3      = 3'b010;
        addr      = 32'h0000_0300;
        wdata     = 32'hA000_0001;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) wait_ready($sformatf("b2b%0d", k));
            @(posedge clk);
            #1;
            acc[k] = cyc;
            addr  = 32'h0000_0300 + 32'(4 * (k + 1));
            wdata = 32'hA000_0001 + 32'(k + 1);
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_gap01", 32'(acc[1] - acc[0]), 32'd2);
        check("b2b_gap12", 32'(acc[2] - acc[1]), 32'd2);
        check("b2b_done_count", 32'(done_cnt - d0), 32'd3);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
